obi_cache_bridge: RTL

OBI slave front-end for the key/value cache. It consumes obi_request_t transactions from the SoC bus and exposes a small register file: KEY, VALUE, CMD and STATUS. A write to CMD launches a GET, PUT or DEL toward the cache controller over a valid/ready handshake, and the block captures the result. Every OBI request gets an obi_response_t exactly one cycle after it is issued.

---
 rtl/croc_pkg.sv | 50 +++++
 rtl/obi_cache_regfile.sv | 98 +++++++++
 rtl/obi_cache_bridge.sv | 106 ++++++++++
 3 files changed

// File: rtl/croc_pkg.sv
// Shared bus and cache-bridge definitions: bus geometry, OBI structs, cache op codes,
// bridge register offsets and bridge FSM states.
package croc_pkg;

    localparam int ARCHITECTURE = 64;
    localparam int KEY_WIDTH    = ARCHITECTURE;
    localparam int VALUE_WIDTH  = 2 * ARCHITECTURE;
    localparam int ADDR_WIDTH   = ARCHITECTURE;
    localparam int DATA_WIDTH   = VALUE_WIDTH;
    localparam int BE_WIDTH     = DATA_WIDTH / 8;
    localparam int KEY_BYTES    = KEY_WIDTH / 8;

    // Byte offsets of the bridge registers inside its 64-byte window.
    localparam logic [5:0] REG_KEY    = 6'h00;
    localparam logic [5:0] REG_VALUE  = 6'h10;
    localparam logic [5:0] REG_CMD    = 6'h20;
    localparam logic [5:0] REG_STATUS = 6'h30;

    localparam int STATUS_BUSY  = 0;
    localparam int STATUS_HIT   = 1;
    localparam int STATUS_ERROR = 2;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_GET  = 2'b01,
        OP_PUT  = 2'b10,
        OP_DEL  = 2'b11
    } cache_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } bridge_state_e;

    typedef struct packed {
        logic                  request;
        logic                  write_enabled;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_WIDTH-1:0]   be;
    } obi_request_t;

    typedef struct packed {
        logic                  valid;
        logic                  error;
        logic [DATA_WIDTH-1:0] data;
    } obi_response_t;

endpackage

// File: rtl/obi_cache_regfile.sv
// Bridge register file: address decode, byte-enabled KEY/VALUE writes, CMD launch
// qualification and the registered one-cycle OBI response.
module obi_cache_regfile
    import croc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  obi_request_t           req,
    output obi_response_t          rsp,
    input  logic                   busy,
    input  logic [2:0]             status,
    input  logic                   value_load,
    input  logic [VALUE_WIDTH-1:0] value_load_data,
    output logic [KEY_WIDTH-1:0]   key,
    output logic [VALUE_WIDTH-1:0] value,
    output logic                   cmd_start,
    output cache_op_e              cmd_op
);

    logic                  in_range;
    logic [5:0]            offset;
    logic                  key_we;
    logic                  value_we;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  unused_addr;

    assign in_range    = (req.addr[ADDR_WIDTH-1:6] == '0);
    assign offset      = {req.addr[5:4], 4'b0000};
    assign cmd_op      = cache_op_e'(req.wdata[1:0]);
    assign unused_addr = ^req.addr[3:0];

    always_comb begin
        err       = 1'b0;
        rdata     = '0;
        key_we    = 1'b0;
        value_we  = 1'b0;
        cmd_start = 1'b0;
        if (!in_range) begin
            err = 1'b1;
        end else begin
            case (offset)
                REG_KEY: begin
                    if (!req.write_enabled) rdata = {{(DATA_WIDTH-KEY_WIDTH){1'b0}}, key};
                    else if (busy)          err = 1'b1;
                    else                    key_we = 1'b1;
                end
                REG_VALUE: begin
                    if (!req.write_enabled) rdata = value;
                    else if (busy)          err = 1'b1;
                    else                    value_we = 1'b1;
                end
                REG_CMD: begin
                    // OP_NONE is not a command; a busy bridge rejects any new launch.
                    if (req.write_enabled) begin
                        if (busy || req.wdata[1:0] == 2'b00) err = 1'b1;
                        else                                 cmd_start = 1'b1;
                    end
                end
                REG_STATUS: begin
                    if (req.write_enabled) err = 1'b1;
                    else                   rdata = {{(DATA_WIDTH-3){1'b0}}, status};
                end
                default: err = 1'b1;
            endcase
        end
        if (!req.request) begin
            err       = 1'b0;
            key_we    = 1'b0;
            value_we  = 1'b0;
            cmd_start = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key   <= '0;
            value <= '0;
            rsp   <= '0;
        end else begin
            rsp.valid <= req.request;
            rsp.error <= err;
            rsp.data  <= req.request ? rdata : '0;
            for (int b = 0; b < KEY_BYTES; b++) begin
                if (key_we && req.be[b]) key[b*8 +: 8] <= req.wdata[b*8 +: 8];
            end
            // A cache load only happens while busy, when bus writes to VALUE are refused.
            if (value_load) begin
                value <= value_load_data;
            end else begin
                for (int b = 0; b < BE_WIDTH; b++) begin
                    if (value_we && req.be[b]) value[b*8 +: 8] <= req.wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/obi_cache_bridge.sv
// OBI front-end for the key/value cache: launches GET/PUT/DEL on a CMD write, waits
// for the cache result with a bounded timeout and records hit/error in STATUS.
module obi_cache_bridge
    import croc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  obi_request_t           obi_req_i,
    output obi_response_t          obi_rsp_o,
    output logic                   cache_req_valid_o,
    input  logic                   cache_req_ready_i,
    output logic [1:0]             cache_op_o,
    output logic [KEY_WIDTH-1:0]   cache_key_o,
    output logic [VALUE_WIDTH-1:0] cache_value_o,
    input  logic                   cache_rsp_valid_i,
    input  logic                   cache_rsp_hit_i,
    input  logic [VALUE_WIDTH-1:0] cache_rsp_value_i
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    bridge_state_e    state;
    cache_op_e        op;
    cache_op_e        cmd_op;
    logic             hit;
    logic             error;
    logic             busy;
    logic             cmd_start;
    logic             value_load;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       status;

    assign busy              = (state != IDLE);
    assign cache_req_valid_o = (state == ISSUE);
    assign cache_op_o        = op;
    assign value_load        = (state == WAIT) && cache_rsp_valid_i && cache_rsp_hit_i
                               && (op == OP_GET);

    always_comb begin
        status               = '0;
        status[STATUS_BUSY]  = busy;
        status[STATUS_HIT]   = hit;
        status[STATUS_ERROR] = error;
    end

    obi_cache_regfile u_regfile (
        .clk             (clk_i),
        .rst_n           (rst_ni),
        .req             (obi_req_i),
        .rsp             (obi_rsp_o),
        .busy            (busy),
        .status          (status),
        .value_load      (value_load),
        .value_load_data (cache_rsp_value_i),
        .key             (cache_key_o),
        .value           (cache_value_o),
        .cmd_start       (cmd_start),
        .cmd_op          (cmd_op)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            op    <= OP_NONE;
            hit   <= 1'b0;
            error <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        op    <= cmd_op;
                        hit   <= 1'b0;
                        error <= 1'b0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cache_req_ready_i) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // A response in the timeout cycle still counts as a normal completion.
                    if (cache_rsp_valid_i) begin
                        hit   <= cache_rsp_hit_i;
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        hit   <= 1'b0;
                        error <= 1'b1;
                        state <= IDLE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
